hdd_sector_server: RTL

HDD_SECTOR_SERVER -- requirements
Module: hdd_sector_server

---
 rtl/hdd_pkg.sv | 19 +
 rtl/hdd_sector_server_if.sv | 37 +++
 rtl/hdd_req_edge.sv | 18 +
 rtl/hdd_sector_server.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hdd_pkg.sv
// Shared types and constants for the HDD sector server.
package hdd_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned BUF_AW       = 9;
  localparam int unsigned LBA_W        = 32;
  localparam int unsigned SEC_W        = 16;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned TMO_W        = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } hdd_state_e;

endpackage

// File: rtl/hdd_sector_server_if.sv
// HDD card buffer port plus host block-device port of the sector server.
interface hdd_sector_server_if;
  import hdd_pkg::*;

  logic [SEC_W-1:0]  hdd_sector;
  logic              hdd_read;
  logic              hdd_write;
  logic [BUF_AW-1:0] hdd_ram_addr;
  logic [DATA_W-1:0] hdd_ram_di;
  logic [DATA_W-1:0] hdd_ram_do;
  logic              hdd_ram_we;
  logic [LBA_W-1:0]  blk_lba;
  logic              blk_rd;
  logic              blk_wr;
  logic              blk_ack;
  logic [BUF_AW-1:0] blk_buff_addr;
  logic [DATA_W-1:0] blk_buff_dout;
  logic              blk_buff_wr;
  logic [DATA_W-1:0] blk_buff_din;
  logic              busy;
  logic              err;

  modport master (
    input  hdd_sector, hdd_read, hdd_write, hdd_ram_do,
           blk_ack, blk_buff_addr, blk_buff_dout, blk_buff_wr,
    output hdd_ram_addr, hdd_ram_di, hdd_ram_we, blk_lba, blk_rd, blk_wr,
           blk_buff_din, busy, err
  );

  modport slave (
    output hdd_sector, hdd_read, hdd_write, hdd_ram_do,
           blk_ack, blk_buff_addr, blk_buff_dout, blk_buff_wr,
    input  hdd_ram_addr, hdd_ram_di, hdd_ram_we, blk_lba, blk_rd, blk_wr,
           blk_buff_din, busy, err
  );

endinterface

// File: rtl/hdd_req_edge.sv
// Rising-edge detector for an HDD request level; history clears in reset.
module hdd_req_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/hdd_sector_server.sv
// Bridges HDD slot-card sector requests onto a host block device.
// Optional watchdog enabled by defining HDD_TIMEOUT_EN.
module hdd_sector_server
  import hdd_pkg::*;
#(
  parameter logic [LBA_W-1:0] LBA_BASE       = 32'h0,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input logic                 clk_sys,
  input logic                 reset_n,
  hdd_sector_server_if.master bus
);

  hdd_state_e        state_q, state_d;
  logic              dir_rd_q, dir_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LBA_W-1:0]  lba_q, lba_d;
  logic              blk_rd_q, blk_rd_d;
  logic              blk_wr_q, blk_wr_d;
  logic              busy_q, busy_d;
  logic [BUF_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_di_q, ram_di_d;
  logic              ram_we_q, ram_we_d;
  logic              tmo_hit_c;
  logic              rd_rise_c, wr_rise_c;
`ifdef HDD_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  hdd_req_edge u_rd_edge (.clk(clk_sys), .rst_n(reset_n), .level(bus.hdd_read),  .rise_c(rd_rise_c));
  hdd_req_edge u_wr_edge (.clk(clk_sys), .rst_n(reset_n), .level(bus.hdd_write), .rise_c(wr_rise_c));

  always_comb begin
    state_d    = state_q;
    dir_rd_d   = dir_rd_q;
    cnt_d      = cnt_q;
    lba_d      = lba_q;
    blk_rd_d   = blk_rd_q;
    blk_wr_d   = blk_wr_q;
    busy_d     = busy_q;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    ram_we_d   = 1'b0;
    tmo_hit_c  = 1'b0;
`ifdef HDD_TIMEOUT_EN
    err_d      = err_q;
    tmo_hit_c  = ((state_q == ST_REQ) || (state_q == ST_XFER)) &&
                 (tmo_q == TIMEOUT_CYCLES - TMO_W'(1));
`endif

    case (state_q)
      ST_IDLE: begin
        // Read wins a simultaneous edge; the write edge is simply lost
        if (rd_rise_c || wr_rise_c) begin
          dir_rd_d = rd_rise_c;
          lba_d    = LBA_W'(bus.hdd_sector) + LBA_BASE;
          blk_rd_d = rd_rise_c;
          blk_wr_d = ~rd_rise_c;
          busy_d   = 1'b1;
          state_d  = ST_REQ;
`ifdef HDD_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        if (tmo_hit_c || bus.blk_ack) begin
          blk_rd_d = 1'b0;
          blk_wr_d = 1'b0;
          state_d  = tmo_hit_c ? ST_DONE : ST_XFER;
`ifdef HDD_TIMEOUT_EN
          err_d    = err_q | tmo_hit_c;
`endif
        end
      end
      ST_XFER: begin
        if (tmo_hit_c || !bus.blk_ack) begin
          state_d = ST_DONE;
`ifdef HDD_TIMEOUT_EN
          err_d   = err_q | tmo_hit_c;
`endif
        end else if (dir_rd_q) begin
          // Bytes past one sector are swallowed so the card buffer is never overrun
          if (bus.blk_buff_wr && (cnt_q < CNT_W'(SECTOR_BYTES))) begin
            ram_we_d   = 1'b1;
            ram_addr_d = bus.blk_buff_addr;
            ram_di_d   = bus.blk_buff_dout;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end else begin
          ram_addr_d = bus.blk_buff_addr;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef HDD_TIMEOUT_EN
    // Watchdog restarts on every state change and only runs while waiting on the host
    if ((state_d != state_q) || !((state_q == ST_REQ) || (state_q == ST_XFER)))
      tmo_d = '0;
    else
      tmo_d = tmo_q + TMO_W'(1);
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dir_rd_q   <= 1'b0;
      cnt_q      <= '0;
      lba_q      <= '0;
      blk_rd_q   <= 1'b0;
      blk_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      ram_we_q   <= 1'b0;
`ifdef HDD_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_rd_q   <= dir_rd_d;
      cnt_q      <= cnt_d;
      lba_q      <= lba_d;
      blk_rd_q   <= blk_rd_d;
      blk_wr_q   <= blk_wr_d;
      busy_q     <= busy_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      ram_we_q   <= ram_we_d;
`ifdef HDD_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.hdd_ram_addr = ram_addr_q;
  assign bus.hdd_ram_di   = ram_di_q;
  assign bus.hdd_ram_we   = ram_we_q;
  assign bus.blk_lba      = lba_q;
  assign bus.blk_rd       = blk_rd_q;
  assign bus.blk_wr       = blk_wr_q;
  assign bus.busy         = busy_q;
  // Buffer read data is already registered inside the card RAM; gate it to the write transfer
  assign bus.blk_buff_din = ((state_q == ST_XFER) && !dir_rd_q) ? bus.hdd_ram_do : '0;
`ifdef HDD_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
